// File: rtl/pc_unit.sv
// Program-counter unit for the multicycle MIPS datapath: next-PC selection,
// exception entry/return through EPC, and a circular return-address stack.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h80000180),
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic [2:0]       pc_src,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             exc_req,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             in_exc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  typedef enum logic {NORMAL, EXC} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pc_next, epc_next;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr, top_inc, top_dec;
  logic [CNT_W-1:0] count;
  logic             take_exc, ras_act;

  assign pc_plus   = pc + WIDTH'(STEP);
  assign in_exc    = (state == EXC);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL_CNT);
  assign ras_top   = ras_empty ? '0 : ras_mem[top_ptr];
  assign top_inc   = top_ptr + PTR_W'(1);
  assign top_dec   = top_ptr - PTR_W'(1);

  // A trap is only taken from NORMAL; once taken it cancels all other activity.
  assign take_exc = exc_req && (state == NORMAL);
  assign ras_act  = pc_write && !take_exc;

  always_comb begin
    pc_next    = pc;
    epc_next   = epc;
    state_next = state;
    if (take_exc) begin
      pc_next    = EXC_VEC;
      epc_next   = pc;
      state_next = EXC;
    end else if (pc_write) begin
      case (pc_src)
        3'd0: pc_next = pc_plus;
        3'd1: pc_next = branch_target;
        3'd2: pc_next = jump_target;
        3'd3: pc_next = reg_target;
        3'd4: pc_next = ras_empty ? reg_target : ras_top;
        3'd5: begin
          pc_next    = epc;
          state_next = NORMAL;
        end
        default: pc_next = pc;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
      pc    <= RESET_VEC;
      epc   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      epc   <= epc_next;
    end
  end

  // Push+pop on a non-empty stack replaces the top; on an empty stack it is a plain push.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
      ras_ovf <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (ras_act) begin
      if (ras_push && ras_pop && !ras_empty) begin
        ras_mem[top_ptr] <= pc_plus;
      end else if (ras_push) begin
        ras_mem[top_inc] <= pc_plus;
        top_ptr          <= top_inc;
        if (ras_full) ras_ovf <= 1'b1;
        else          count   <= count + CNT_W'(1);
      end else if (ras_pop && !ras_empty) begin
        top_ptr <= top_dec;
        count   <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: expected PCs are queued when stimulus is
// driven and popped when the DUT's committed PC is sampled.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic [2:0]  pc_src;
  logic [31:0] branch_target, jump_target, reg_target;
  logic        exc_req, ras_push, ras_pop;
  logic [31:0] pc, pc_plus, epc, ras_top;
  logic        in_exc, ras_empty, ras_full, ras_ovf;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_pc;

  pc_unit dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_src(pc_src),
    .branch_target(branch_target), .jump_target(jump_target), .reg_target(reg_target),
    .exc_req(exc_req), .ras_push(ras_push), .ras_pop(ras_pop),
    .pc(pc), .pc_plus(pc_plus), .epc(epc), .in_exc(in_exc),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf)
  );

  // DUT commits on the falling edge; the bench drives and samples at the rising edge.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input logic w, input logic [2:0] src, input logic [31:0] bt,
                      input logic [31:0] jt, input logic [31:0] rt,
                      input logic exc, input logic push, input logic pop);
    pc_write = w; pc_src = src; branch_target = bt; jump_target = jt;
    reg_target = rt; exc_req = exc; ras_push = push; ras_pop = pop;
    @(posedge clk);
  endtask

  task automatic test_reset_initial();
    checks++;
    if (pc !== 32'h0 || epc !== 32'h0 || in_exc !== 1'b0 || ras_empty !== 1'b1 ||
        ras_ovf !== 1'b0 || ras_top !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_initial: pc=%h epc=%h in_exc=%b empty=%b ovf=%b top=%h required 0/0/0/1/0/0",
               pc, epc, in_exc, ras_empty, ras_ovf, ras_top);
    end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(32'(4 * k));
      step(1, 0, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 0, 0);
      exp_pc = exp_q.pop_front();
      checks++;
      if (pc !== exp_pc) begin
        failures++;
        $display("[TB] FAIL seq_inc%0d: pc=%h required %h", k, pc, exp_pc);
      end
    end
    exp_q.push_back(32'hFFFFFFFC);
    step(1, 2, 32'hB0B0, 32'hFFFFFFFC, 32'hD0D0, 0, 0, 0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc || pc_plus !== 32'h0) begin
      failures++;
      $display("[TB] FAIL seq_top: pc=%h pc_plus=%h required %h / 0", pc, pc_plus, exp_pc);
    end
    exp_q.push_back(32'h0);
    step(1, 0, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 0, 0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc) begin
      failures++;
      $display("[TB] FAIL seq_wrap: pc=%h required %h", pc, exp_pc);
    end
  endtask

  task automatic test_sources();
    logic [2:0]  srcs  [6] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0};
    logic        wr    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exps  [6] = '{32'h100, 32'h4000, 32'h88, 32'h88, 32'h88, 32'h88};
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(exps[k]);
      step(wr[k], srcs[k], 32'h100, 32'h4000, 32'h88, 0, 0, 0);
      exp_pc = exp_q.pop_front();
      checks++;
      if (pc !== exp_pc) begin
        failures++;
        $display("[TB] FAIL src_%0d_w%0b: pc=%h required %h", srcs[k], wr[k], pc, exp_pc);
      end
    end
  endtask

  task automatic test_exception();
    step(1, 2, 32'hB0B0, 32'h40, 32'hD0D0, 0, 0, 0);
    exp_q.push_back(32'h80000180);
    step(1, 1, 32'h999, 32'hC0C0, 32'hD0D0, 1, 0, 0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc || epc !== 32'h40 || in_exc !== 1'b1) begin
      failures++;
      $display("[TB] FAIL exc_entry: pc=%h epc=%h in_exc=%b required %h/00000040/1", pc, epc, in_exc, exp_pc);
    end
    exp_q.push_back(32'h80000184);
    step(1, 0, 32'hB0B0, 32'hC0C0, 32'hD0D0, 1, 0, 0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc || epc !== 32'h40 || in_exc !== 1'b1) begin
      failures++;
      $display("[TB] FAIL exc_nested: pc=%h epc=%h in_exc=%b required %h/00000040/1", pc, epc, in_exc, exp_pc);
    end
    exp_q.push_back(32'h40);
    step(1, 5, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 0, 0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc || in_exc !== 1'b0) begin
      failures++;
      $display("[TB] FAIL exc_eret: pc=%h in_exc=%b required %h/0", pc, in_exc, exp_pc);
    end
    step(1, 2, 32'hB0B0, 32'h70, 32'hD0D0, 0, 0, 0);
    exp_q.push_back(32'h40);
    step(1, 5, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 0, 0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc || in_exc !== 1'b0) begin
      failures++;
      $display("[TB] FAIL eret_normal: pc=%h in_exc=%b required %h/0", pc, in_exc, exp_pc);
    end
  endtask

  task automatic test_ras();
    logic [31:0] pops [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
    step(1, 2, 32'hB0B0, 32'h10, 32'hD0D0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(32'(16 * k + 4));
      step(1, 2, 32'hB0B0, 32'(16 * (k + 1)), 32'hD0D0, 0, 1, 0);
      exp_pc = exp_q.pop_front();
      checks++;
      if (ras_top !== exp_pc || ras_full !== (k >= 4) || ras_ovf !== (k == 5)) begin
        failures++;
        $display("[TB] FAIL ras_push%0d: top=%h full=%b ovf=%b required %h/%b/%b",
                 k, ras_top, ras_full, ras_ovf, exp_pc, (k >= 4), (k == 5));
      end
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(pops[k]);
      step(1, 4, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 0, 1);
      exp_pc = exp_q.pop_front();
      checks++;
      if (pc !== exp_pc || ras_empty !== (k == 3)) begin
        failures++;
        $display("[TB] FAIL ras_pop%0d: pc=%h empty=%b required %h/%b", k, pc, ras_empty, exp_pc, (k == 3));
      end
    end
    exp_q.push_back(32'h200);
    step(1, 4, 32'hB0B0, 32'hC0C0, 32'h200, 0, 0, 0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc || ras_top !== 32'h0) begin
      failures++;
      $display("[TB] FAIL ras_fallback: pc=%h top=%h required %h/0", pc, ras_top, exp_pc);
    end
  endtask

  task automatic test_edge_cases();
    step(1, 2, 32'hB0B0, 32'h20, 32'hD0D0, 0, 0, 0);
    step(1, 2, 32'hB0B0, 32'h60, 32'hD0D0, 0, 1, 0);
    exp_q.push_back(32'h64);
    step(1, 0, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 1, 1);
    exp_pc = exp_q.pop_front();
    checks++;
    if (ras_top !== exp_pc || pc !== 32'h64 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
      failures++;
      $display("[TB] FAIL push_pop: top=%h pc=%h empty=%b full=%b required %h/00000064/0/0",
               ras_top, pc, ras_empty, ras_full, exp_pc);
    end
    exp_q.push_back(32'h80000180);
    step(1, 0, 32'hB0B0, 32'hC0C0, 32'hD0D0, 1, 1, 0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc || ras_top !== 32'h64 || epc !== 32'h64) begin
      failures++;
      $display("[TB] FAIL exc_push: pc=%h top=%h epc=%h required %h/00000064/00000064", pc, ras_top, epc, exp_pc);
    end
    step(1, 5, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 0, 0);
    exp_q.push_back(32'h64);
    step(0, 0, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 1, 0);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc || ras_top !== 32'h64) begin
      failures++;
      $display("[TB] FAIL nowrite_push: pc=%h top=%h required %h/00000064", pc, ras_top, exp_pc);
    end
    exp_q.push_back(32'h64);
    step(1, 4, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 0, 1);
    exp_pc = exp_q.pop_front();
    checks++;
    if (pc !== exp_pc || ras_empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_pop: pc=%h empty=%b required %h/1", pc, ras_empty, exp_pc);
    end
    exp_q.push_back(32'h68);
    step(1, 0, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 1, 1);
    exp_pc = exp_q.pop_front();
    checks++;
    if (ras_top !== exp_pc || ras_empty !== 1'b0 || pc !== 32'h68) begin
      failures++;
      $display("[TB] FAIL push_pop_empty: top=%h empty=%b pc=%h required %h/0/00000068", ras_top, ras_empty, pc, exp_pc);
    end
  endtask

  task automatic test_reset_midrun();
    step(0, 0, 32'hB0B0, 32'hC0C0, 32'hD0D0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0 || epc !== 32'h0 || in_exc !== 1'b0 || ras_empty !== 1'b1 ||
        ras_ovf !== 1'b0 || ras_top !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_midrun: pc=%h epc=%h in_exc=%b empty=%b ovf=%b top=%h required 0/0/0/1/0/0",
               pc, epc, in_exc, ras_empty, ras_ovf, ras_top);
    end
    rst = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pc_write = 0; pc_src = 0; branch_target = 0; jump_target = 0; reg_target = 0;
    exc_req = 0; ras_push = 0; ras_pop = 0;
    @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    test_reset_initial();
    test_sequential();
    test_sources();
    test_exception();
    test_ras();
    test_edge_cases();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
